apb_master_arbiter: RTL

Shares one APB master port between `NUM_REQ` local requesters and sequences each transfer through the APB IDLE, SETUP and ACCESS phases. Arbitration is round-robin. Each granted request is latched and driven onto `psel`, `penable`, `pwrite`, `paddr` and `pwdata`. The block waits for `pready`, then returns `prdata` or a timeout error to the granted requester. It drives the DRV-side signals of the APB interface, and its bus activity is what the APB input and output monitors observe.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_rr_arbiter.sv | 49 ++++
 rtl/apb_master_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master arbiter: default bus widths and FSM states.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus a registered last-winner pointer.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic                       grant_en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] last;

    // Search starting just after the previous winner, wrapping once around all requesters.
    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_any && req_valid[IW'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = IW'(cand);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Remember the most recent winner; out of reset requester 0 is first in line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= IW'(NUM_REQ - 1);
        end else if (grant_en) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, IDLE/SETUP/ACCESS
// sequencing, wait-state counting with optional timeout abort, and a one-cycle
// response pulse back to the winning requester.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int addrWidth = APB_ADDR_WIDTH,
    parameter int dataWidth = APB_DATA_WIDTH,
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*addrWidth-1:0] req_addr,
    input  logic [NUM_REQ*dataWidth-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [dataWidth-1:0]         rsp_rdata,
    output logic                         rsp_err,
    output logic                         psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [addrWidth-1:0]         paddr,
    output logic [dataWidth-1:0]         pwdata,
    input  logic [dataWidth-1:0]         prdata,
    input  logic                         pready
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen during the last ACCESS cycle allowed before abort.
    localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e         state;
    logic [IW-1:0]      cur_idx;
    logic [CW-1:0]      wait_cnt;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;
    logic               grant_en;

    // Arbitration only counts while idle and out of reset; ready is the grant itself.
    assign grant_en  = reset && (state == IDLE) && grant_any;
    assign req_ready = grant_en ? grant : '0;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Transfer sequencer: latches the winner's request, walks SETUP/ACCESS, and
    // issues the completion or timeout pulse; bus fields hold until the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_idx   <= '0;
            wait_cnt  <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        pwrite   <= req_write[grant_idx];
                        paddr    <= req_addr[grant_idx*addrWidth +: addrWidth];
                        pwdata   <= req_wdata[grant_idx*dataWidth +: dataWidth];
                        cur_idx  <= grant_idx;
                        wait_cnt <= '0;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= NUM_REQ'(1) << cur_idx;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                        rsp_valid <= NUM_REQ'(1) << cur_idx;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
